// File: rtl/wb_burst_read_streamer.sv
// Wishbone B3 burst-read DMA master.
// Drains a memory buffer into a FWFT valid/ready stream.
module wb_burst_read_streamer #(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 5,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  output logic [WB_DW-1:0]   stream_data,
  output logic               stream_valid,
  input  logic               stream_ready,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [WB_AW-1:0]   rx_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [WB_AW-1:0] STEP  = WB_AW'(WB_DW / 8);
  localparam logic [WB_AW-1:0] ONE   = WB_AW'(1);
  localparam logic [WB_AW-1:0] MAXBL = WB_AW'(MAX_BURST_LEN);
  localparam logic [WB_AW-1:0] DEPW  = WB_AW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_BURST, S_FIN
  } state_t;

  state_t             state_q;
  logic               en_q;
  logic [WB_AW-1:0]   adr_q;
  logic [WB_AW-1:0]   rem_q;
  logic [WB_AW-1:0]   beats_q;
  logic [WB_AW-1:0]   rx_q;
  logic               cyc_q;
  logic [2:0]         cti_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [WB_DW-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q;
  logic [FIFO_AW-1:0] rp_q;
  logic [FIFO_AW:0]   lvl_q;

  logic [WB_AW-1:0]   eb;
  logic [WB_AW-1:0]   len;
  logic [WB_AW-1:0]   free;
  logic               rise;
  logic               push;
  logic               pop;
  logic               flush;

  // Burst length for the next burst and FIFO room from the registered level
  always_comb begin
    eb = burst_size;
    if (burst_size == '0)
      eb = ONE;
    else if (burst_size > MAXBL)
      eb = MAXBL;
    len  = (rem_q < eb) ? rem_q : eb;
    free = DEPW - WB_AW'(lvl_q);
  end

  assign rise  = enable & ~en_q;
  assign push  = cyc_q & wbm_ack_i & ~wbm_err_i;
  assign pop   = stream_valid & stream_ready;
  assign flush = (state_q == S_IDLE) & ~enable;

  // Transfer sequencer; all bus and status outputs are registered here
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      adr_q   <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      rx_q    <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q   <= enable;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            adr_q   <= start_adr;
            rem_q   <= buf_size;
            rx_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (buf_size == '0) ? S_FIN : S_WAIT;
          end
        end
        S_WAIT: begin
          if (free >= len) begin
            beats_q <= len;
            cyc_q   <= 1'b1;
            cti_q   <= (len == ONE) ? 3'b111 : 3'b010;
            state_q <= S_BURST;
          end
        end
        S_BURST: begin
          if (wbm_err_i) begin
            cyc_q   <= 1'b0;
            cti_q   <= 3'b000;
            err_q   <= 1'b1;
            state_q <= S_FIN;
          end else if (wbm_ack_i) begin
            adr_q   <= adr_q + STEP;
            rem_q   <= rem_q - ONE;
            beats_q <= beats_q - ONE;
            rx_q    <= rx_q + ONE;
            if (beats_q == ONE) begin
              cyc_q   <= 1'b0;
              cti_q   <= 3'b000;
              state_q <= (rem_q == ONE || !enable) ? S_FIN : S_WAIT;
            end else if (beats_q == WB_AW'(2)) begin
              cti_q <= 3'b111;
            end
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and level; push and pop together leave the level unchanged
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push)
        wp_q <= wp_q + 1'b1;
      if (pop)
        rp_q <= rp_q + 1'b1;
      lvl_q <= lvl_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end

  // FIFO storage
  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem_q[wp_q] <= wbm_dat_i;
  end

  assign stream_data  = mem_q[rp_q];
  assign stream_valid = (lvl_q != '0);

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cti_o = cti_q;
  assign wbm_bte_o = 2'b00;

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = err_q;
  assign rx_cnt = rx_q;

endmodule

// File: tb/tb_wb_burst_read_streamer.sv
// Directed bench for wb_burst_read_streamer.
// Memory word at address a reads as a ^ 32'hA5A5_0000.
module tb_wb_burst_read_streamer;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr, dat_o, dat_i, sdata;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        svalid, sready;
  logic        enable;
  logic [31:0] start_adr, buf_size, burst_size, rx_cnt;
  logic        busy, done, error;
  logic        err_en;
  logic [31:0] err_adr;

  always #5 clk = ~clk;

  wb_burst_read_streamer dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_o),
    .wbm_sel_o   (sel),
    .wbm_we_o    (we),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_cti_o   (cti),
    .wbm_bte_o   (bte),
    .wbm_dat_i   (dat_i),
    .wbm_ack_i   (ack),
    .wbm_err_i   (err),
    .stream_data (sdata),
    .stream_valid(svalid),
    .stream_ready(sready),
    .enable      (enable),
    .start_adr   (start_adr),
    .buf_size    (buf_size),
    .burst_size  (burst_size),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .rx_cnt      (rx_cnt)
  );

  // zero-wait slave: acks every strobed cycle
  assign ack   = cyc & stb;
  assign err   = cyc & err_en & (adr == err_adr);
  assign dat_i = adr ^ K;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] b_adr[$];
  logic [2:0]  b_cti[$];
  logic [31:0] s_dat[$];
  int          done_n = 0;
  int          err_late = 0;
  bit          err_seen = 0;

  always @(posedge clk) begin
    if (err_seen && cyc) err_late++;
    err_seen = cyc && err;
    if (cyc && ack && !err) begin
      b_adr.push_back(adr);
      b_cti.push_back(cti);
    end
    if (svalid && sready) s_dat.push_back(sdata);
    if (done) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [31:0] sa, input logic [31:0] bs,
                       input logic [31:0] bu);
    @(negedge clk);
    start_adr  = sa;
    buf_size   = bs;
    burst_size = bu;
    enable     = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic stop_en();
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_stream(input string tag, input int s0,
                            input logic [31:0] sa, input int n);
    int bad = 0;
    chk({tag, "_words"}, 32'(s_dat.size() - s0), 32'(n));
    if (s_dat.size() - s0 == n)
      for (int i = 0; i < n; i++)
        if (s_dat[s0+i] !== ((sa + 32'(4*i)) ^ K)) bad++;
    chk({tag, "_data_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int b0, s0, d0;
    enable = 0; sready = 1; err_en = 0; err_adr = '0;
    start_adr = '0; buf_size = '0; burst_size = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_cti", 32'(cti), 0);
    chk("rst_adr", adr, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stat", {29'd0, done, error, svalid}, 0);
    chk("rst_rx", rx_cnt, 0);
    rst = 0;
    @(negedge clk);

    // two 4-beat bursts
    b0 = b_adr.size(); s0 = s_dat.size(); d0 = done_n;
    start(32'h1000, 8, 4);
    wait_done("t1", 100);
    repeat (5) @(negedge clk);
    chk("t1_beats", 32'(b_adr.size() - b0), 8);
    if (b_adr.size() - b0 == 8) begin
      chk("t1_adr0", b_adr[b0], 32'h1000);
      chk("t1_adr4", b_adr[b0+4], 32'h1010);
      for (int i = 0; i < 8; i++)
        chk("t1_cti", 32'(b_cti[b0+i]), (i % 4 == 3) ? 7 : 2);
    end
    chk_stream("t1", s0, 32'h1000, 8);
    chk("t1_donecnt", 32'(done_n - d0), 1);
    chk("t1_rx", rx_cnt, 8);
    chk("t1_busy", 32'(busy), 0);
    stop_en();

    // 4 + 1 beats
    b0 = b_adr.size(); s0 = s_dat.size();
    start(32'h1000, 5, 4);
    wait_done("t2", 100);
    repeat (5) @(negedge clk);
    chk("t2_beats", 32'(b_adr.size() - b0), 5);
    if (b_adr.size() - b0 == 5) begin
      chk("t2_adr4", b_adr[b0+4], 32'h1010);
      chk("t2_cti3", 32'(b_cti[b0+3]), 7);
      chk("t2_cti4", 32'(b_cti[b0+4]), 7);
    end
    chk_stream("t2", s0, 32'h1000, 5);
    stop_en();

    // backpressure fills FIFO
    b0 = b_adr.size(); s0 = s_dat.size();
    sready = 0;
    start(32'h4000, 64, 16);
    repeat (200) @(negedge clk);
    chk("t3_fill_beats", 32'(b_adr.size() - b0), 32);
    chk("t3_fill_cyc", 32'(cyc), 0);
    chk("t3_fill_rx", rx_cnt, 32);
    chk("t3_head", sdata, 32'h4000 ^ K);
    sready = 1;
    wait_done("t3", 600);
    repeat (40) @(negedge clk);
    chk("t3_beats", 32'(b_adr.size() - b0), 64);
    chk("t3_rx", rx_cnt, 64);
    chk_stream("t3", s0, 32'h4000, 64);
    stop_en();

    // bus error on beat 3
    b0 = b_adr.size(); s0 = s_dat.size(); d0 = done_n;
    sready = 0; err_en = 1; err_adr = 32'h2008;
    start(32'h2000, 4, 4);
    wait_done("t4", 100);
    repeat (3) @(negedge clk);
    chk("t4_error", 32'(error), 1);
    chk("t4_rx", rx_cnt, 2);
    chk("t4_late_cyc", 32'(err_late), 0);
    chk("t4_donecnt", 32'(done_n - d0), 1);
    chk("t4_valid", 32'(svalid), 1);
    err_en = 0;
    sready = 1;
    repeat (5) @(negedge clk);
    chk_stream("t4", s0, 32'h2000, 2);
    stop_en();

    // enable drops during burst 1
    b0 = b_adr.size(); d0 = done_n;
    start(32'h3000, 16, 8);
    for (int i = 0; i < 50 && (b_adr.size() - b0) < 3; i++)
      @(negedge clk);
    enable = 0;
    wait_done("t5", 100);
    repeat (3) @(negedge clk);
    chk("t5_beats", 32'(b_adr.size() - b0), 8);
    chk("t5_rx", rx_cnt, 8);
    chk("t5_donecnt", 32'(done_n - d0), 1);
    stop_en();

    // zero-length transfer
    b0 = b_adr.size();
    start(32'h6000, 0, 4);
    @(negedge clk);
    chk("t6_done_early", 32'(done), 0);
    chk("t6_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t6_done", 32'(done), 1);
    repeat (3) @(negedge clk);
    chk("t6_beats", 32'(b_adr.size() - b0), 0);
    stop_en();

    // burst_size 0 -> single beats
    b0 = b_adr.size(); s0 = s_dat.size();
    start(32'h5000, 3, 0);
    wait_done("t7", 100);
    repeat (5) @(negedge clk);
    chk("t7_beats", 32'(b_adr.size() - b0), 3);
    if (b_adr.size() - b0 == 3)
      for (int i = 0; i < 3; i++)
        chk("t7_cti", 32'(b_cti[b0+i]), 7);
    chk_stream("t7", s0, 32'h5000, 3);
    stop_en();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
